// File: rtl/req_gnt_pkg.sv
// Shared types and default parameters for the tagged req/gnt grant-side responder.
package req_gnt_pkg;

  localparam int ID_W_DEF    = 2;
  localparam int DEPTH_DEF   = 4;
  localparam int MIN_LAT_DEF = 3;
  localparam int AGE_W_DEF   = $clog2(MIN_LAT_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    GAP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [AGE_W_DEF-1:0] age;
  } entry_t;

endpackage

// File: rtl/tag_age_fifo.sv
// In-order tag FIFO; every slot carries an age counter that saturates at MIN_LAT.
module tag_age_fifo
  import req_gnt_pkg::*;
#(
  parameter int ID_W    = ID_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int MIN_LAT = MIN_LAT_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [ID_W-1:0]                  push_id,
  input  logic                             pop,
  output logic                             full,
  output logic                             empty,
  output logic [ID_W-1:0]                  head_id,
  output logic [$clog2(MIN_LAT+1)-1:0]     head_age
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int AGE_W = $clog2(MIN_LAT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MIN_LAT);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [ID_W-1:0]  id_mem [DEPTH];
  logic [AGE_W-1:0] age_q  [DEPTH];
  logic [AGE_W-1:0] age_d  [DEPTH];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // Flags are derived from next-state pointers so they appear the cycle after the push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop & ~empty_q);
    count_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (count_d == PW'(DEPTH));
    empty_d  = (count_d == '0);
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_idx == AW'(i))) begin
        age_d[i] = '0;
      end else if (age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_idx] <= push_id;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign head_id  = id_mem[rd_idx];
  assign head_age = age_q[rd_idx];

endmodule

// File: rtl/req_gnt_responder.sv
// Grant-side responder: captures rising req edges with their tag and returns one
// single-cycle gnt per capture, in order, after the entry has aged MIN_LAT cycles.
module req_gnt_responder
  import req_gnt_pkg::*;
#(
  parameter int ID_W    = ID_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int MIN_LAT = MIN_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic [ID_W-1:0] req_id,
  input  logic            gnt_en,
  output logic            gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            full,
  output logic            overflow
);

  localparam int AGE_W = $clog2(MIN_LAT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MIN_LAT);

  state_e           state_q, state_d;
  logic             req_q;
  logic             gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic             capture, push, pop;
  logic             fifo_full, fifo_empty;
  logic [ID_W-1:0]  head_id;
  logic [AGE_W-1:0] head_age;

  assign capture = req & ~req_q;
  assign pop     = (state_q == GRANT);
  // A full queue still accepts a capture when the head leaves in the same cycle.
  assign push    = capture & (~fifo_full | pop);

  tag_age_fifo #(
    .ID_W    (ID_W),
    .DEPTH   (DEPTH),
    .MIN_LAT (MIN_LAT)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_id  (req_id),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_id  (head_id),
    .head_age (head_age)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = WAIT;
      WAIT:    if ((head_age == AGE_MAX) && gnt_en) state_d = GRANT;
      GRANT:   state_d = GAP;
      GAP:     state_d = fifo_empty ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d      = (state_d == GRANT);
    gnt_id_d   = (state_d == GRANT) ? head_id : gnt_id_q;
    busy_d     = push | ~fifo_empty | (state_d != IDLE);
    overflow_d = overflow_q | (capture & fifo_full & ~pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      gnt_q      <= 1'b0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign gnt      = gnt_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;
  assign full     = fifo_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_req_gnt_responder.sv
// Directed bench for req_gnt_responder: stimulus pushes expected grants into a
// scoreboard, a negedge monitor pops and checks id, latency window and spacing.
module tb_req_gnt_responder;

  localparam int LAT     = 5;
  localparam int NOLIMIT = 1 << 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [1:0] req_id;
  logic       gnt_en;
  logic       gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       full;
  logic       overflow;

  req_gnt_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_id   (req_id),
    .gnt_en   (gnt_en),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] exp_id_q [$];
  int         lo_q     [$];
  int         hi_q     [$];
  logic       prev_gnt = 1'b0;
  logic [1:0] mon_id;
  int         mon_lo;
  int         mon_hi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [1:0] id, input int lo, input int hi);
    exp_id_q.push_back(id);
    lo_q.push_back(lo);
    hi_q.push_back(hi);
  endtask

  // One-cycle request pulse followed by one low cycle so the next call gives a fresh edge.
  task automatic do_req(input logic [1:0] id, input bit expect_gnt, input bit exact);
    int cap;
    @(negedge clk);
    req    = 1'b1;
    req_id = id;
    cap    = edge_cnt + 1;
    if (expect_gnt) push_exp(id, cap + LAT, exact ? cap + LAT : NOLIMIT);
    $display("[TB] req id=%0d capture_edge=%0d expect_gnt=%0d", id, cap, expect_gnt);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_id_q.size() != 0; i++) @(negedge clk);
    n_tests++;
    if (exp_id_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d grants still outstanding, expected 0", exp_id_q.size());
      exp_id_q.delete();
      lo_q.delete();
      hi_q.delete();
    end
  endtask

  // Monitor: every grant seen must match the scoreboard head, in its window, and not follow a grant.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = 1'b0;
    end else begin
      if (gnt === 1'b1) begin
        check("gnt_spacing", 32'(prev_gnt), 32'd0);
        if (exp_id_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_gnt: got gnt with id=%0d, expected no grant", gnt_id);
        end else begin
          mon_id = exp_id_q.pop_front();
          mon_lo = lo_q.pop_front();
          mon_hi = hi_q.pop_front();
          $display("[TB] gnt id=%0d sampled_edge=%0d exp_id=%0d", gnt_id, edge_cnt + 1, mon_id);
          check("gnt_id", 32'(gnt_id), 32'(mon_id));
          n_tests++;
          if ((edge_cnt + 1 < mon_lo) || (edge_cnt + 1 > mon_hi)) begin
            n_fail++;
            $display("FAIL gnt_latency: got edge %0d, expected window [%0d,%0d]",
                     edge_cnt + 1, mon_lo, mon_hi);
          end
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    req    = 1'b0;
    req_id = 2'd0;
    gnt_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_gnt_id", 32'(gnt_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request, exact minimum latency
    do_req(2'd2, 1'b1, 1'b1);
    check("single_busy", 32'(busy), 32'd1);
    wait_drain(50);
    repeat (3) @(negedge clk);
    check("single_busy_idle", 32'(busy), 32'd0);

    // Two requests three cycles apart
    do_req(2'd2, 1'b1, 1'b0);
    do_req(2'd3, 1'b1, 1'b0);
    wait_drain(50);
    repeat (4) @(negedge clk);

    // Grant withheld for 20 cycles, then exactly one cycle after gnt_en is seen
    gnt_en = 1'b0;
    do_req(2'd1, 1'b1, 1'b0);
    lo_q[0] = NOLIMIT;
    repeat (20) @(negedge clk);
    check("withheld_busy", 32'(busy), 32'd1);
    @(negedge clk);
    gnt_en  = 1'b1;
    lo_q[0] = edge_cnt + 2;
    hi_q[0] = edge_cnt + 2;
    wait_drain(20);
    repeat (4) @(negedge clk);

    // Overflow: four fill the queue, the fifth is dropped
    gnt_en = 1'b0;
    do_req(2'd0, 1'b1, 1'b0);
    do_req(2'd1, 1'b1, 1'b0);
    do_req(2'd2, 1'b1, 1'b0);
    check("ovf_not_full_at_3", 32'(full), 32'd0);
    do_req(2'd3, 1'b1, 1'b0);
    check("ovf_full_at_4", 32'(full), 32'd1);
    check("ovf_clear_at_4", 32'(overflow), 32'd0);
    do_req(2'd0, 1'b0, 1'b0);
    check("ovf_set_at_5", 32'(overflow), 32'd1);
    gnt_en = 1'b1;
    wait_drain(60);
    repeat (10) @(negedge clk);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_not_full", 32'(full), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("ovf_cleared_by_reset", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // req held high for 3 cycles gives one capture
    @(negedge clk);
    req    = 1'b1;
    req_id = 2'd3;
    push_exp(2'd3, edge_cnt + 1 + LAT, edge_cnt + 1 + LAT);
    $display("[TB] req id=3 held 3 cycles capture_edge=%0d", edge_cnt + 1);
    repeat (3) @(negedge clk);
    req = 1'b0;
    wait_drain(40);
    repeat (12) @(negedge clk);

    // Asynchronous reset while waiting with two entries queued
    gnt_en = 1'b0;
    do_req(2'd1, 1'b0, 1'b0);
    do_req(2'd2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("prereset_busy", 32'(busy), 32'd1);
    check("prereset_gnt_id", 32'(gnt_id), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_gnt_id", 32'(gnt_id), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_full", 32'(full), 32'd0);
    check("async_rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    gnt_en = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'd0);

    // Capture while full coincides with a grant: accepted, no overflow
    gnt_en = 1'b0;
    do_req(2'd3, 1'b1, 1'b0);
    do_req(2'd2, 1'b1, 1'b0);
    do_req(2'd1, 1'b1, 1'b0);
    do_req(2'd0, 1'b1, 1'b0);
    check("pf_full", 32'(full), 32'd1);
    @(negedge clk);
    gnt_en = 1'b1;
    @(negedge clk);
    check("pf_in_grant", 32'(gnt), 32'd1);
    check("pf_full_at_capture", 32'(full), 32'd1);
    req    = 1'b1;
    req_id = 2'd2;
    push_exp(2'd2, edge_cnt + 1 + LAT, NOLIMIT);
    $display("[TB] req id=2 capture_edge=%0d during grant at full", edge_cnt + 1);
    @(negedge clk);
    req = 1'b0;
    check("pf_still_full", 32'(full), 32'd1);
    wait_drain(80);
    repeat (6) @(negedge clk);
    check("pf_no_overflow", 32'(overflow), 32'd0);
    check("pf_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
